// File: rtl/byte_assembler.sv
// byte_assembler: collects a framed serial bit stream into one byte
// and pulses load_en so a downstream enabled register captures it.
// Ports:
//   clk, reset (sync, active-high)
//   start, bit_valid, bit_in : frame strobe and serial bit input
//   d_out[7:0], load_en      : byte and enable for downstream register
//   busy, frame_err          : frame in progress, parity failure pulse
// Optional parity check (9th bit, even parity) when
// BYTE_ASM_PARITY_EN is defined; otherwise frame_err is tied low.
module byte_assembler #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] d_out,
  output logic       load_en,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    LOAD  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] d_q, d_nxt;
  logic [7:0] shifted;

  assign shifted = MSB_FIRST ? {shreg[6:0], bit_in}
                             : {bit_in, shreg[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      shreg <= 8'h00;
      d_q   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
      d_q   <= d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    d_nxt     = d_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = 3'd0;
          shreg_nxt = 8'h00;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_nxt   = 3'd0;
          shreg_nxt = 8'h00;
        end else if (bit_valid) begin
          shreg_nxt = shifted;
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef BYTE_ASM_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = LOAD;
            d_nxt     = shifted;
`endif
          end
        end
      end
`ifdef BYTE_ASM_PARITY_EN
      PAR: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = 3'd0;
          shreg_nxt = 8'h00;
        end else if (bit_valid) begin
          // 9-bit even parity: the extra bit must equal ^data
          if (bit_in == ^shreg) begin
            state_nxt = LOAD;
            d_nxt     = shreg;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR:  state_nxt = IDLE;
`endif
      LOAD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign d_out   = d_q;
  assign load_en = (state == LOAD);
  assign busy    = (state == SHIFT) || (state == PAR);
`ifdef BYTE_ASM_PARITY_EN
  assign frame_err = (state == ERR);
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_assembler.sv
// tb_byte_assembler: scoreboard bench driving an MSB-first and an
// LSB-first instance from the same serial stream.
module tb_byte_assembler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] d_m, d_l;
  logic       ld_m, ld_l;
  logic       busy_m, busy_l;
  logic       err_m, err_l;
  logic [7:0] q_m, q_l;

  int checks = 0;
  int errors = 0;
  int loads = 0;
  int errs_seen = 0;
  int err_exp = 0;
  logic [7:0] qm_exp[$];
  logic [7:0] ql_exp[$];
  logic       chk_q = 1'b0;
  logic [7:0] qm_want, ql_want;

  byte_assembler #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .start(start),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .d_out(d_m), .load_en(ld_m), .busy(busy_m),
    .frame_err(err_m)
  );

  byte_assembler #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .start(start),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .d_out(d_l), .load_en(ld_l), .busy(busy_l),
    .frame_err(err_l)
  );

  always #5 clk = ~clk;

  // downstream enabled registers
  always @(posedge clk) begin
    if (ld_m) q_m <= d_m;
    if (ld_l) q_l <= d_l;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (chk_q) begin
        checks++;
        if (q_m !== qm_want || q_l !== ql_want) begin
          errors++;
          $display("FAIL q_update: got %h/%h want %h/%h",
                   q_m, q_l, qm_want, ql_want);
        end
        chk_q = 1'b0;
      end
      if (ld_m || ld_l) begin
        loads++;
        checks++;
        if (qm_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: d_out %h/%h", d_m, d_l);
        end else begin
          qm_want = qm_exp.pop_front();
          ql_want = ql_exp.pop_front();
          if (!(ld_m && ld_l) || d_m !== qm_want
              || d_l !== ql_want) begin
            errors++;
            $display("FAIL load_data: got %h/%h ld %b%b want %h/%h",
                     d_m, d_l, ld_m, ld_l, qm_want, ql_want);
          end
          chk_q = 1'b1;
        end
      end
      if (err_m || err_l) begin
        errs_seen++;
        checks++;
        if (err_exp == 0 || !(err_m && err_l)) begin
          errors++;
          $display("FAIL unexpected_frame_err: got %b%b want 0",
                   err_m, err_l);
        end else begin
          err_exp--;
        end
      end
      if ((ld_m && err_m) || (ld_l && err_l)) begin
        checks++;
        errors++;
        $display("FAIL pulse_overlap: load_en and frame_err both 1");
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b0;
    repeat (gap) cycle();
    bit_valid = 1'b1;
    bit_in = b;
    cycle();
    bit_valid = 1'b0;
  endtask

  // sends start + 8 bits (b[7] first) [+ parity], checks the final
  // LOAD/ERR cycle, optionally holds start during it
  task automatic send_frame(input logic [7:0] b, input int gap,
                            input logic par_flip,
                            input logic start_in_load);
    logic ok;
    ok = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
`ifdef BYTE_ASM_PARITY_EN
        send_bit(b[0], gap);
        ok = !par_flip;
        if (ok) begin
          qm_exp.push_back(b);
          ql_exp.push_back(rev8(b));
        end else begin
          err_exp++;
        end
        send_bit((^b) ^ par_flip, gap);
`else
        qm_exp.push_back(b);
        ql_exp.push_back(rev8(b));
        send_bit(b[0], gap);
`endif
      end else begin
        send_bit(b[i], gap);
      end
    end
    checks++;
    if (ld_m !== ok || err_m !== !ok || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL final_cycle: ld %b err %b busy %b want %b %b 0",
               ld_m, err_m, busy_m, ok, !ok);
    end
    start = start_in_load;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cycle();
    checks++;
    if (d_m !== 8'h00 || d_l !== 8'h00 || busy_m !== 1'b0
        || ld_m !== 1'b0 || err_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: d %h/%h busy %b ld %b err %b",
               d_m, d_l, busy_m, ld_m, err_m);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_msb_byte();
    int l0;
    l0 = loads;
    send_frame(8'h48, 1, 1'b0, 1'b0);
    cycle();
    checks++;
    if (loads - l0 != 1 || d_m !== 8'h48 || d_l !== 8'h12) begin
      errors++;
      $display("FAIL msb_byte: loads %0d d %h/%h want 1 48/12",
               loads - l0, d_m, d_l);
    end
  endtask

  task automatic test_lsb_byte();
    send_frame(8'h12, 0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (d_l !== 8'h48 || d_m !== 8'h12) begin
      errors++;
      $display("FAIL lsb_byte: d %h/%h want 12/48", d_m, d_l);
    end
  endtask

  task automatic test_reset_mid_frame();
    int l0;
    l0 = loads;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame: got %b want 1", busy_m);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (d_m !== 8'h00 || d_l !== 8'h00 || busy_m !== 1'b0
        || ld_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: d %h/%h busy %b ld %b",
               d_m, d_l, busy_m, ld_m);
    end
    repeat (3) cycle();
    checks++;
    if (loads != l0) begin
      errors++;
      $display("FAIL reset_no_load: loads %0d want %0d", loads, l0);
    end
    send_frame(8'h09, 0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (d_m !== 8'h09 || d_l !== 8'h90) begin
      errors++;
      $display("FAIL after_reset_frame: d %h/%h want 09/90",
               d_m, d_l);
    end
  endtask

  task automatic test_restart();
    int l0;
    l0 = loads;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    // restart with a bit that must be discarded
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    cycle();
    start = 1'b0;
    bit_valid = 1'b0;
    qm_exp.push_back(8'h11);
    ql_exp.push_back(8'h88);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'h11;
      send_bit(v[i], 0);
    end
`ifdef BYTE_ASM_PARITY_EN
    send_bit(1'b0, 0);
`endif
    repeat (3) cycle();
    checks++;
    if (loads - l0 != 1 || d_m !== 8'h11 || d_l !== 8'h88) begin
      errors++;
      $display("FAIL restart: loads %0d d %h/%h want 1 11/88",
               loads - l0, d_m, d_l);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 0, 1'b0, 1'b1);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL start_in_load: busy %b want 0", busy_m);
    end
    send_frame(8'h3C, 0, 1'b0, 1'b0);
    checks++;
    if (d_m !== 8'h3C || d_l !== 8'h3C) begin
      errors++;
      $display("FAIL back_to_back: d %h/%h want 3c/3c", d_m, d_l);
    end
  endtask

  task automatic test_parity();
`ifdef BYTE_ASM_PARITY_EN
    int e0;
    e0 = errs_seen;
    send_frame(8'h5C, 0, 1'b0, 1'b0);
    send_frame(8'h6C, 0, 1'b1, 1'b0);
    cycle();
    checks++;
    if (errs_seen - e0 != 1 || d_m !== 8'h5C || d_l !== 8'h3A) begin
      errors++;
      $display("FAIL parity: errs %0d d %h/%h want 1 5c/3a",
               errs_seen - e0, d_m, d_l);
    end
`else
    send_frame(8'h5C, 0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (err_m !== 1'b0 || d_m !== 8'h5C || d_l !== 8'h3A) begin
      errors++;
      $display("FAIL no_parity_frame: err %b d %h/%h want 0 5c/3a",
               err_m, d_m, d_l);
    end
`endif
  endtask

  task automatic test_ignored_inputs();
    int l0;
    int bad;
    l0 = loads;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = i[0];
      bit_in = i[1];
      cycle();
      if (busy_m !== 1'b0 || busy_l !== 1'b0) bad++;
    end
    bit_valid = 1'b0;
    cycle();
    checks++;
    if (bad != 0 || loads != l0) begin
      errors++;
      $display("FAIL ignored_inputs: busy_hits %0d loads %0d want 0",
               bad, loads - l0);
    end
  endtask

  initial begin
    test_reset();
    test_msb_byte();
    test_lsb_byte();
    test_reset_mid_frame();
    test_restart();
    test_back_to_back();
    test_parity();
    test_ignored_inputs();
    repeat (3) cycle();
    checks++;
    if (qm_exp.size() != 0 || err_exp != 0) begin
      errors++;
      $display("FAIL missing_outputs: loads %0d errs %0d want 0",
               qm_exp.size(), err_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_assembler.md
# byte_assembler

Serial-to-parallel front end that collects a framed bit stream into one byte and presents it to the downstream 8-bit enabled register. It drives that register's data input from `d_out` and its enable from `load_en`, so the register captures exactly one new byte per completed frame and holds it otherwise. An optional parity check rejects corrupted frames before they reach the register.

## Interface
- `MSB_FIRST`, 1, bit order of the serial stream: 1 = first bit received lands in `d_out[7]`; 0 = first bit lands in `d_out[0]`.

- `clk`  input  1  rising-edge clock, shared with the downstream register.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  frame start strobe; sampled every cycle.
- `bit_valid`  input  1  `bit_in` is valid this cycle.
- `bit_in`  input  1  serial data bit.
- `d_out`  output  8  last accepted byte; drives the downstream register's `d`.
- `load_en`  output  1  one-cycle pulse; drives the downstream register's `en`.
- `busy`  output  1  a frame is in progress.
- `frame_err`  output  1  one-cycle pulse on a parity failure.

One clock domain. Reset is synchronous and active-high. Ports are `clk` and `reset`.

## Operation
- **States:** IDLE, SHIFT, PAR, LOAD, ERR.
- **IDLE:**
  - `start` = 1 → SHIFT. The bit counter and the shift register are cleared.
  - `bit_valid` in IDLE is ignored.
  - If `start` and `bit_valid` are both high in IDLE, `start` is taken and the bit is discarded.
- **SHIFT:**
  - Each `bit_valid` cycle shifts `bit_in` into `shreg` and increments the 3-bit counter.
  - `MSB_FIRST` = 1: `shreg <= {shreg[6:0], bit_in}`. `MSB_FIRST` = 0: `shreg <= {bit_in, shreg[7:1]}`.
  - Gaps are allowed: with `bit_valid` = 0 the state holds and nothing changes.
  - When the 8th bit is accepted (counter wraps 7 → 0), the next state is LOAD, or PAR when parity is compiled in.
- **PAR:**
  - The next `bit_valid` bit is compared with `^shreg` (even parity over 9 bits).
  - Match → LOAD. Mismatch → ERR.
- **LOAD:** `load_en` = 1 for this cycle only, then → IDLE.
- **ERR:** `frame_err` = 1 for this cycle only. `d_out` is unchanged. Then → IDLE.
- **Restart:** `start` = 1 in SHIFT or PAR restarts the frame.
  - Counter and `shreg` are cleared and the state goes to SHIFT.
  - Any `bit_valid` in the same cycle is discarded. `start` has priority over `bit_valid`.
- **`busy`:** 1 in SHIFT and PAR; 0 in IDLE, LOAD and ERR.
- **`d_out`:** changes only on entry to LOAD and holds its value between loads.
- **Reset values:** state = IDLE, counter = 0, `shreg` = 8'h00, `d_out` = 8'h00, `load_en` = 0, `busy` = 0, `frame_err` = 0.
- **Reset mid-frame:** the partial byte is dropped, no `load_en` pulse is produced, and `d_out` returns to 8'h00.

## Timing
- **Load timing:** `d_out` and the state register update on the same rising edge that accepts the final bit (the 8th data bit, or the parity bit when enabled).
  - `load_en` is high for the following cycle.
  - The downstream register captures `d_out` on the next edge.
  - Latency from the final bit's sampling edge to the downstream `q` update is 1 clock.
- **Frame rate:**
  - Minimum frame is 1 `start` cycle + 8 `bit_valid` cycles + 1 LOAD cycle (+1 parity cycle when enabled).
  - A `start` asserted during LOAD or ERR is ignored. The next `start` is honoured from IDLE, one cycle later.
- **Output registers:** `load_en`, `frame_err` and `busy` are decoded from the state register only, with no combinational path from inputs. The two pulses are never high together.

## Configuration
- **Macro:** `BYTE_ASM_PARITY_EN`.
- **Defined:** the PAR and ERR states exist and `frame_err` is driven as described.
- **Undefined:**
  - SHIFT goes directly to LOAD after the 8th bit.
  - PAR and ERR are never entered.
  - `frame_err` is tied to 0.
  - No 9th bit is consumed.

## Test plan
- **MSB-first byte:** reset for 2 cycles, then `start`, then bits 0,1,0,0,1,0,0,0 with 1-cycle gaps between them → `load_en` pulses once, `d_out` = 8'h48, `busy` falls in the LOAD cycle, and the downstream `q` = 8'h48 one edge later.
- **LSB-first byte:** with `MSB_FIRST` = 0, `start` then bits 0,0,0,1,0,0,1,0 → `d_out` = 8'h48.
- **Reset mid-frame:** after a prior load of 8'h48, send `start` and 4 bits, then assert `reset` for 1 cycle → no `load_en` pulse, `d_out` = 8'h00, `busy` = 0; a following full frame of 8'h09 loads normally.
- **Restart:** `start`, 5 bits, `start` again together with `bit_valid` = 1, then 8 bits for 8'h11 → the bit in the restart cycle is discarded and exactly one `load_en` pulse occurs, with `d_out` = 8'h11.
- **Parity (`BYTE_ASM_PARITY_EN` defined):**
  - Frame 8'h5C with parity bit 0 → `load_en` pulses, `d_out` = 8'h5C.
  - Frame 8'h6C with parity bit 1 → `frame_err` pulses for 1 cycle, no `load_en`, `d_out` stays 8'h5C.
- **Ignored inputs:** `bit_valid` toggling in IDLE with no `start` → no state change, `busy` = 0, and no pulses on either output.
